// File: rtl/core_issue_ctrl_pkg.sv
// Shared types and constants for the issue controller and its scoreboard.
package core_issue_ctrl_pkg;

   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned REG_IDX_W = 5;
   localparam logic [NUM_REGS-1:0] ZERO_WORD = '0;

   typedef enum logic [0:0] {
      S_RUN     = 1'b0,
      S_BC_WAIT = 1'b1
   } state_e;

   function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [REG_IDX_W-1:0] idx);
      logic [NUM_REGS-1:0] oh;
      oh = ZERO_WORD;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/core_issue_scoreboard.sv
// Busy-register scoreboard: tracks pending writers and flags RAW/WAW hazards
// against the registered busy vector (no writeback bypass).
module core_issue_scoreboard
   import core_issue_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 set_en,
   input  logic [REG_IDX_W-1:0] set_idx,
   input  logic                 clr_en,
   input  logic [REG_IDX_W-1:0] clr_idx,
   input  logic [REG_IDX_W-1:0] rs1_idx,
   input  logic                 rs1_used,
   input  logic [REG_IDX_W-1:0] rs2_idx,
   input  logic                 rs2_used,
   input  logic [REG_IDX_W-1:0] rd_idx,
   input  logic                 rd_wen,
   output logic                 haz,
   output logic [NUM_REGS-1:0]  busy_vec
);

   logic [NUM_REGS-1:0] busy_d, busy_q;

   // Clear is applied after set so a coinciding clear wins; x0 is never busy.
   always_comb begin
      busy_d = busy_q;
      if (set_en) busy_d = busy_d | idx_onehot(set_idx);
      if (clr_en) busy_d = busy_d & ~idx_onehot(clr_idx);
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         busy_q <= ZERO_WORD;
      end else begin
         busy_q <= busy_d;
      end
   end

   always_comb begin
      haz = (rs1_used && busy_q[rs1_idx]) ||
            (rs2_used && busy_q[rs2_idx]) ||
            (rd_wen   && busy_q[rd_idx]);
   end

   assign busy_vec = busy_q;

   set_clr_collide_a: assert property (@(posedge clk) disable iff (!rstn)
      !(set_en && clr_en && (set_idx == clr_idx) && (set_idx != '0)));

endmodule

// File: rtl/core_issue_ctrl.sv
// Issue controller: gates IDU->EXU issue on scoreboard hazards, serializes
// control-transfer instructions and pulses a flush on taken resolution.
module core_issue_ctrl
   import core_issue_ctrl_pkg::*;
#(
   parameter int unsigned STALL_CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   idu_valid,
   output logic                   idu_ready,
   input  logic [4:0]             idu_rs1_idx,
   input  logic [4:0]             idu_rs2_idx,
   input  logic                   idu_rs1_used,
   input  logic                   idu_rs2_used,
   input  logic [4:0]             idu_rd_idx,
   input  logic                   idu_rd_wen,
   input  logic                   idu_is_bc,
   output logic                   exu_rx_valid,
   input  logic                   exu_rx_ready,
   input  logic                   exu_tx_valid,
   input  logic                   exu_tx_ready,
   input  logic                   exu_tx_bc_done,
   input  logic                   exu_tx_bc_en,
   input  logic                   wbu_wb_valid,
   input  logic [4:0]             wbu_wb_rd_idx,
   output logic                   ctrl_flush,
   output logic [31:0]            ctrl_busy_vec,
   output logic [STALL_CNT_W-1:0] ctrl_stall_cnt
);

   state_e                 state_d, state_q;
   logic                   flush_d, flush_q;
   logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;
   logic                   haz, go, issue, res;

   core_issue_scoreboard u_scoreboard (
      .clk      (clk),
      .rstn     (rstn),
      .set_en   (issue && idu_rd_wen),
      .set_idx  (idu_rd_idx),
      .clr_en   (wbu_wb_valid),
      .clr_idx  (wbu_wb_rd_idx),
      .rs1_idx  (idu_rs1_idx),
      .rs1_used (idu_rs1_used),
      .rs2_idx  (idu_rs2_idx),
      .rs2_used (idu_rs2_used),
      .rd_idx   (idu_rd_idx),
      .rd_wen   (idu_rd_wen),
      .haz      (haz),
      .busy_vec (ctrl_busy_vec)
   );

   always_comb begin
      go           = (state_q == S_RUN) && !haz && !flush_q;
      exu_rx_valid = idu_valid && go;
      idu_ready    = exu_rx_ready && go;
      issue        = idu_valid && idu_ready;
      res          = exu_tx_valid && exu_tx_ready && exu_tx_bc_done;
   end

   always_comb begin
      state_d = state_q;
      flush_d = 1'b0;
      unique case (state_q)
         S_RUN: begin
            if (issue && idu_is_bc) state_d = S_BC_WAIT;
         end
         S_BC_WAIT: begin
            if (res) begin
               flush_d = exu_tx_bc_en;
               state_d = S_RUN;
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (idu_valid && !idu_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_RUN;
         flush_q     <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_q     <= flush_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign ctrl_flush     = flush_q;
   assign ctrl_stall_cnt = stall_cnt_q;

endmodule
